imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 7 +
 rtl/imem_addr_check.sv | 12 +
 rtl/imem_arbiter.sv | 99 +++++++++
 tb/tb_imem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared state encoding and response constants for the
// instruction-memory arbiter.
package imem_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_FETCH, ARB_LOAD} arb_state_t;
    localparam logic [31:0] ZERO          = 32'h0000_0000;
    localparam logic [31:0] IMEM_ERR_WORD = 32'hdead_beef;
endpackage

// File: rtl/imem_addr_check.sv
// imem_addr_check: flags word accesses that are misaligned, in the upper half
// of the address space, or run past the end of the instruction memory.
module imem_addr_check
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic [31:0] addr,
    output logic        err
);
    assign err = (addr >= 32'(MEM_DEPTH - 3)) || addr[31] || (addr[1:0] != ZERO[1:0]);
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction memory between fetch and a loader.
// Define IMEM_ARB_STARVE_EN to force a fetch grant after STARVE_LIMIT denials.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        l_req,
    input  logic        l_we,
    input  logic        l_lock,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        l_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic [31:0] mem_data_out
);
    arb_state_t  state_q, state_d;
    logic        f_bad, l_bad, force_f, keep_l;
    logic        f_rvalid_q, l_rvalid_q, f_err_q, l_err_q;
    logic [31:0] f_rdata_q, l_rdata_q;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    imem_addr_check #(.MEM_DEPTH(MEM_DEPTH)) u_f_chk (.addr(f_addr), .err(f_bad));
    imem_addr_check #(.MEM_DEPTH(MEM_DEPTH)) u_l_chk (.addr(l_addr), .err(l_bad));

`ifdef IMEM_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    assign force_f      = f_req && (starve_cnt_q == CW'(STARVE_LIMIT));
    assign starve_cnt_d = (!f_req || f_gnt) ? '0 :
                          (starve_cnt_q == CW'(STARVE_LIMIT)) ? starve_cnt_q : starve_cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (!rst)
            starve_cnt_q <= '0;
        else
            starve_cnt_q <= starve_cnt_d;
    end
`else
    assign force_f = 1'b0;
`endif

    // A locked loader keeps the port; otherwise it wins on plain priority.
    assign keep_l = (state_q == ARB_LOAD) && l_lock && l_req;
    assign l_gnt  = rst && !force_f && (keep_l || l_req);
    assign f_gnt  = rst && f_req && !l_gnt;

    assign mem_addr     = l_gnt ? l_addr : f_gnt ? f_addr : ZERO;
    assign mem_data_in  = l_gnt ? l_wdata : ZERO;
    assign mem_write_en = l_gnt && l_we && !l_bad;
    assign mem_read_en  = f_gnt || (l_gnt && !l_we);
    assign state_d      = l_gnt ? ARB_LOAD : f_gnt ? ARB_FETCH : ARB_IDLE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            f_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            l_err_q    <= 1'b0;
            f_rdata_q  <= ZERO;
            l_rdata_q  <= ZERO;
        end else begin
            state_q    <= state_d;
            f_rvalid_q <= f_gnt;
            l_rvalid_q <= l_gnt;
            f_err_q    <= f_gnt && f_bad;
            l_err_q    <= l_gnt && l_bad;
            if (f_gnt)
                f_rdata_q <= f_bad ? IMEM_ERR_WORD : mem_data_out;
            if (l_gnt)
                l_rdata_q <= l_we ? ZERO : l_bad ? IMEM_ERR_WORD : mem_data_out;
        end
    end

    assign f_rvalid = f_rvalid_q;
    assign f_rdata  = f_rdata_q;
    assign f_err    = f_err_q;
    assign l_rvalid = l_rvalid_q;
    assign l_rdata  = l_rdata_q;
    assign l_err    = l_err_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and random checks of imem_arbiter against a
// transaction-level model; follows IMEM_ARB_STARVE_EN like the design.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;
    localparam int DEPTH = 1024;
    localparam int LIM   = 4;
`ifdef IMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0;
    logic        f_req, f_gnt, f_rvalid, f_err;
    logic [31:0] f_addr, f_rdata;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_read_en, mem_write_en;

    always #5 clk = ~clk;

    imem_arbiter #(.MEM_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid),
        .l_rdata(l_rdata), .l_err(l_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_data_out(mem_data_out)
    );

    // Memory environment: unwritten words return a fixed address pattern.
    function automatic logic [31:0] base(input logic [31:0] a);
        return (a[9:2] == 8'h04) ? 32'h0050_0093 : {8'h5A, a[9:2], ~a[9:2], 8'hC3};
    endfunction

    bit [31:0]  env_mem [256];
    bit [255:0] env_wr;
    assign mem_data_out = env_wr[mem_addr[9:2]] ? env_mem[mem_addr[9:2]] : base(mem_addr);
    always @(posedge clk)
        if (mem_write_en) begin
            env_mem[mem_addr[9:2]] <= mem_data_in;
            env_wr[mem_addr[9:2]]  <= 1'b1;
        end

    // Reference model state
    bit [31:0]  ref_mem [256];
    bit [255:0] ref_wr;
    int         starve, total, bad;
    logic       last_fgnt;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : base(a);
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
        return (a >= 32'(DEPTH - 3)) || a[31] || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] raddr();
        int k = $urandom_range(0, 7);
        logic [31:0] w = $urandom_range(0, 255) << 2;
        return k == 0 ? $urandom() : k == 1 ? 32'h3F8 + 32'($urandom_range(0, 8)) : w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit fr, input logic [31:0] fa, input bit lr, input bit lw,
                         input bit lk, input logic [31:0] la, input logic [31:0] ld);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_lock = lk; l_addr = la; l_wdata = ld;
    endtask

    // One clock: check grants/memory port, then the registered response.
    task automatic cyc();
        bit force_f, eg_f, eg_l, fe, le;
        logic [31:0] ef, el;
        #1;
        force_f = STARVE && f_req && starve == LIM;
        eg_l = rst && l_req && !force_f;
        eg_f = rst && f_req && !eg_l;
        fe = bad_addr(f_addr);
        le = bad_addr(l_addr);
        last_fgnt = f_gnt;
        chk("f_gnt", 32'(f_gnt), 32'(eg_f));
        chk("l_gnt", 32'(l_gnt), 32'(eg_l));
        chk("mem_write_en", 32'(mem_write_en), 32'(eg_l && l_we && !le));
        chk("mem_read_en", 32'(mem_read_en), 32'(eg_f || (eg_l && !l_we)));
        chk("mem_addr", mem_addr, eg_l ? l_addr : eg_f ? f_addr : 32'h0);
        ef = fe ? 32'hdead_beef : ref_rd(f_addr);
        el = l_we ? 32'h0 : le ? 32'hdead_beef : ref_rd(l_addr);
        if (eg_l && l_we && !le) begin
            ref_mem[l_addr[9:2]] = l_wdata;
            ref_wr[l_addr[9:2]]  = 1'b1;
        end
        starve = (!rst || !f_req || eg_f) ? 0 : (starve < LIM ? starve + 1 : LIM);
        @(posedge clk);
        #1;
        chk("f_rvalid", 32'(f_rvalid), 32'(eg_f));
        chk("l_rvalid", 32'(l_rvalid), 32'(eg_l));
        if (eg_f) begin
            chk("f_rdata", f_rdata, ef);
            chk("f_err", 32'(f_err), 32'(fe));
        end
        if (eg_l) begin
            chk("l_rdata", l_rdata, el);
            chk("l_err", 32'(l_err), 32'(le));
        end
        if (!rst) begin
            chk("f_rdata_rst", f_rdata, 32'h0);
            chk("l_rdata_rst", l_rdata, 32'h0);
            chk("f_err_rst", 32'(f_err), 32'h0);
            chk("l_err_rst", 32'(l_err), 32'h0);
            chk("state_rst", 32'(dut.state_q), 32'(ARB_IDLE));
        end
    endtask

    initial begin
        int first;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        // Plain fetch
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        cyc();
        chk("fetch_0x10", f_rdata, 32'h0050_0093);
        // Loader write beats a simultaneous fetch, then fetch sees the data
        drive(1, 32'h20, 1, 1, 0, 32'h20, 32'hCAFE_F00D);
        cyc();
        drive(1, 32'h20, 0, 0, 0, 0, 0);
        cyc();
        chk("fetch_0x20", f_rdata, 32'hCAFE_F00D);
        // Out-of-range write is suppressed
        drive(0, 0, 1, 1, 0, 32'h3FE, 32'h1234_5678);
        cyc();
        chk("oob_write_err", 32'(l_err), 32'h1);
        // Misaligned fetch
        drive(1, 32'h6, 0, 0, 0, 0, 0);
        cyc();
        chk("misalign_rdata", f_rdata, 32'hdead_beef);
        // Boundaries: last legal word, first illegal word, high half
        drive(0, 0, 1, 1, 0, 32'h3FC, 32'h0BAD_CAFE);
        cyc();
        drive(1, 32'h3FC, 0, 0, 0, 0, 0);
        cyc();
        drive(1, 32'h400, 0, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 1, 0, 0, 32'h8000_0010, 0);
        cyc();
        drive(0, 0, 1, 0, 0, 32'h20, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        // Locked loader versus waiting fetch
        first = 0;
        drive(1, 32'h44, 1, 0, 1, 32'h40, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (last_fgnt === 1'b1 && first == 0)
                first = i;
        end
        chk("starve_first_fgnt", 32'(first), STARVE ? 32'd5 : 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        // Reset right after a grant, with a write pending during reset
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;
        drive(0, 0, 1, 1, 0, 32'h30, 32'hBAD0_0001);
        cyc();
        cyc();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        drive(1, 32'h30, 0, 0, 0, 0, 0);
        cyc();
        chk("no_write_in_reset", f_rdata, base(32'h30));
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 24) != 0);
            drive(1'($urandom_range(0, 1)), raddr(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raddr(), $urandom());
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
